// File: rtl/i2c_master.sv
// Single-master I2C byte engine: START, 7-bit address + R/W, up to MAX_BYTES data bytes, STOP.
// Define I2C_MASTER_READ_EN to build the READ/MACK path; otherwise every transaction is a write.
module i2c_master #(
  parameter int CLK_DIV   = 250,
  parameter int MAX_BYTES = 4,
  localparam int NB_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_send,
  input  logic [6:0]             dev_addr,
  input  logic                   rw,
  input  logic [NB_W-1:0]        num_bytes,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  output logic [8*MAX_BYTES-1:0] rd_data,
  output logic                   is_busy,
  output logic                   is_done,
  output logic                   is_nack,
  output logic                   sclk,
  inout  wire                    sdin
);

  localparam int QW = CLK_DIV / 4;
  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = 8 * MAX_BYTES;
`ifdef I2C_MASTER_READ_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK,
`ifdef I2C_MASTER_READ_EN
    READ, MACK,
`endif
    STOP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [6:0]      addr_q;
  logic            rw_q, ack_s, sda_low, sda_in;
  logic [NB_W-1:0] nb_q, byte_idx;
  logic [2:0]      bit_cnt;
  logic [7:0]      tx_sr;
  logic [DW-1:0]   wr_q, rd_q;

  wire wrap     = (cnt == CW'(CLK_DIV - 1));
  wire q2       = (cnt >= CW'(2 * QW));
  wire q3       = (cnt >= CW'(3 * QW));
  wire q3_start = (cnt == CW'(3 * QW));
  wire last     = (NB_W'(byte_idx + 1'b1) == nb_q);
  wire accept   = is_send && !is_busy && (state == IDLE);

  assign sda_in = sdin;
  assign sdin   = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= wrap ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    sclk    = 1'b1;
    sda_low = 1'b0;
    case (state)
      START:     sda_low = q2;
      ADDR,
      WRITE:     begin sclk = q2; sda_low = !tx_sr[7]; end
      ADDR_ACK,
      WRITE_ACK: sclk = q2;
      // sclk rises at Q2 while SDA is still low; SDA release at Q3 is the stop edge
      STOP:      begin sclk = q2; sda_low = !q3; end
`ifdef I2C_MASTER_READ_EN
      READ:      sclk = q2;
      MACK:      begin sclk = q2; sda_low = !last; end
`endif
      default: ;
    endcase
    if (wrap) begin
      case (state)
        IDLE:      if (is_busy) state_n = START;
        START:     state_n = ADDR;
        ADDR:      if (bit_cnt == 3'd7) state_n = ADDR_ACK;
        ADDR_ACK: begin
          if (ack_s || nb_q == '0) state_n = STOP;
`ifdef I2C_MASTER_READ_EN
          else if (rw_q)           state_n = READ;
`endif
          else                     state_n = WRITE;
        end
        WRITE:     if (bit_cnt == 3'd7) state_n = WRITE_ACK;
        WRITE_ACK: state_n = (ack_s || last) ? STOP : WRITE;
`ifdef I2C_MASTER_READ_EN
        READ:      if (bit_cnt == 3'd7) state_n = MACK;
        MACK:      state_n = last ? STOP : READ;
`endif
        STOP:      state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_busy  <= 1'b0;
      is_done  <= 1'b0;
      is_nack  <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      nb_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tx_sr    <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      ack_s    <= 1'b1;
    end else begin
      is_done <= 1'b0;
      if (accept) begin
        is_busy <= 1'b1;
        is_nack <= 1'b0;
        addr_q  <= dev_addr;
        rw_q    <= rw & RD_EN;
        nb_q    <= (num_bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : num_bytes;
        wr_q    <= wr_data;
      end
      if (q3_start) begin
        ack_s <= sda_in;
        if (RD_EN && state_n == state && state_t'(state) != IDLE && state_is_read(state))
          rd_q <= {rd_q[DW-2:0], sda_in};
      end
      if (wrap) begin
        case (state)
          START: begin
            tx_sr   <= {addr_q, rw_q};
            bit_cnt <= '0;
          end
          ADDR, WRITE: begin
            tx_sr   <= tx_sr << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
          ADDR_ACK, WRITE_ACK: begin
            if (ack_s) is_nack <= 1'b1;
            // next payload byte is taken from the MSB end of the latched buffer
            tx_sr    <= wr_q[DW-1 -: 8];
            wr_q     <= wr_q << 8;
            bit_cnt  <= '0;
            byte_idx <= (state == ADDR_ACK) ? '0 : NB_W'(byte_idx + 1'b1);
          end
`ifdef I2C_MASTER_READ_EN
          READ: bit_cnt  <= bit_cnt + 1'b1;
          MACK: byte_idx <= NB_W'(byte_idx + 1'b1);
`endif
          STOP: begin
            is_busy <= 1'b0;
            is_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic state_is_read(input state_t s);
`ifdef I2C_MASTER_READ_EN
    return s == READ;
`else
    return 1'b0 & (s == IDLE);
`endif
  endfunction

`ifdef I2C_MASTER_READ_EN
  assign rd_data = rd_q;
`else
  assign rd_data = rd_q & '0;
`endif

endmodule
